// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the fetch stage and control_unit.
// Holds the instruction width, the bubble word, the PC step and the fetch FSM encoding.
package cpu_pkg;

    localparam int          INSTR_W  = 32;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam int unsigned PC_STEP  = 4;

    typedef enum logic [1:0] {
        S_FILL     = 2'd0,
        S_RUN      = 2'd1,
        S_REDIRECT = 2'd2
    } state_e;

    // Instruction fetches are word aligned; low address bits are dropped silently.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if_id_stage_if.sv
// Fetch-stage bus: hazard/branch controls, instruction-memory port and IF/ID outputs.
// slave = fetch stage side, master = environment driving controls and memory data.
interface fetch_if_id_stage_if;
    import cpu_pkg::*;

    logic               hazard_stall;
    logic               branch_taken;
    logic [INSTR_W-1:0] branch_target;
    logic [INSTR_W-1:0] instr_addr;
    logic [INSTR_W-1:0] instr_data;
    logic [INSTR_W-1:0] if_id_instruction;
    logic [INSTR_W-1:0] if_id_pc_plus4;
    logic               if_id_valid;

    modport slave (
        input  hazard_stall, branch_taken, branch_target, instr_data,
        output instr_addr, if_id_instruction, if_id_pc_plus4, if_id_valid
    );

    modport master (
        output hazard_stall, branch_taken, branch_target, instr_data,
        input  instr_addr, if_id_instruction, if_id_pc_plus4, if_id_valid
    );

endinterface

// File: rtl/fetch_if_id_stage_if_id_register.sv
// IF/ID pipeline register with flush (load bubble) > load > hold priority.
// A flush leaves pc_plus4 untouched; only instruction and valid describe the bubble.
module if_id_register
    import cpu_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP = NOP_WORD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               flush_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [INSTR_W-1:0] pc_plus4_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [INSTR_W-1:0] pc_plus4_o,
    output logic               valid_o
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] pc4_q, pc4_d;
    logic               valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (flush_i) begin
            instr_d = NOP;
            valid_d = 1'b0;
        end else if (load_i) begin
            instr_d = instr_i;
            pc4_d   = pc_plus4_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= NOP;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_if_id_stage.sv
// Instruction fetch stage: owns the PC, drives instruction memory, feeds IF/ID.
// Optional macro BRANCH_DELAY_SLOT_EN: taken branches keep the delay-slot instruction instead of flushing.
module fetch_if_id_stage #(
    parameter logic [31:0]  RESET_PC = 32'h0000_0000,
    parameter int unsigned  PC_STEP  = cpu_pkg::PC_STEP,
    parameter logic [31:0]  NOP_WORD = cpu_pkg::NOP_WORD
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_if_id_stage_if.slave   bus
);
    import cpu_pkg::*;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_seq;
    logic        ifid_load;
    logic        ifid_flush;

    // Sequential address wraps naturally modulo 2^32.
    assign pc_seq = pc_q + 32'(PC_STEP);

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FILL;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FILL: begin
                if (bus.branch_taken)       state_d = S_REDIRECT;
                else if (!bus.hazard_stall) state_d = S_RUN;
            end
            S_RUN: begin
                if (bus.branch_taken)       state_d = S_REDIRECT;
            end
            S_REDIRECT: begin
                if (bus.branch_taken)       state_d = S_REDIRECT;
                else if (!bus.hazard_stall) state_d = S_RUN;
            end
            default:                        state_d = S_FILL;
        endcase
    end

    // Branch overrides a simultaneous stall; the stalled instruction is on the wrong path anyway.
    always_comb begin
        pc_d       = pc_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        if (bus.branch_taken) begin
            pc_d = align_word(bus.branch_target);
`ifdef BRANCH_DELAY_SLOT_EN
            ifid_load  = 1'b1;
`else
            ifid_flush = 1'b1;
`endif
        end else if (!bus.hazard_stall) begin
            pc_d      = pc_seq;
            ifid_load = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

    assign bus.instr_addr = pc_q;

    if_id_register #(
        .NOP (NOP_WORD)
    ) u_if_id (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ifid_load),
        .flush_i    (ifid_flush),
        .instr_i    (bus.instr_data),
        .pc_plus4_i (pc_seq),
        .instr_o    (bus.if_id_instruction),
        .pc_plus4_o (bus.if_id_pc_plus4),
        .valid_o    (bus.if_id_valid)
    );

endmodule
